// File: rtl/aoc_day3_pkg.sv
// Shared constants, FSM encoding and width helper for the joltage selector.
package aoc_day3_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        StAccept,
        StConvert,
        StEmit
    } state_e;

    // Bits needed to hold any k-digit decimal number: ceil(log2(10^k)).
    function automatic int unsigned val_width(input int unsigned k);
        logic [63:0] pow10;
        int unsigned w;
        pow10 = 64'd1;
        for (int unsigned n = 0; n < k; n++) begin
            pow10 = pow10 * 64'd10;
        end
        w = 0;
        for (int unsigned b = 0; b < 64; b++) begin
            if ((64'd1 << b) < pow10) w = b + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/joltage_stack.sv
// Monotonic digit stack keeping the largest in-order K-digit selection of a bank.
module joltage_stack
    import aoc_day3_pkg::*;
#(
    parameter int unsigned K        = 12,
    parameter int unsigned LINE_LEN = 100
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      push_i,
    input  logic [DIGIT_W-1:0]        digit_i,
    input  logic [7:0]                pos_i,
    output logic [K-1:0][DIGIT_W-1:0] stack_o
);

    localparam int unsigned CNT_W = $clog2(K + 1);

    logic [K-1:0][DIGIT_W-1:0] stack_q, stack_d;
    logic [CNT_W-1:0]          size_q, size_d;

    int   rem, lb, sz, tgt;
    logic run, wr_en;

    always_comb begin
        rem   = int'(LINE_LEN) - int'(pos_i);
        // Entries below lb must stay, or too few digits would remain to fill K slots.
        lb    = (int'(K) > rem) ? int'(K) - rem : 0;
        sz    = int'(size_q);
        tgt   = sz;
        run   = 1'b1;
        for (int q = int'(K) - 1; q >= 0; q--) begin
            if (run && q < sz && q >= lb) begin
                if (stack_q[q] < digit_i) tgt = q;
                else run = 1'b0;
            end
        end
        wr_en   = (tgt < sz) || (sz < int'(K));
        stack_d = stack_q;
        size_d  = size_q;
        if (flush_i) begin
            size_d = '0;
        end else if (push_i && wr_en) begin
            for (int q = 0; q < int'(K); q++) begin
                if (q == tgt) stack_d[q] = digit_i;
            end
            size_d = CNT_W'(tgt + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) size_q <= '0;
        else        size_q <= size_d;
    end

    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign stack_o = stack_q;

endmodule

// File: rtl/joltage_selector.sv
// Streams digit banks, selects the largest K-digit subsequence of each and sums them.
module joltage_selector
    import aoc_day3_pkg::*;
#(
    parameter int unsigned K        = 12,
    parameter int unsigned LINE_LEN = 100,
    parameter int unsigned ACC_W    = 64,
    localparam int unsigned VAL_W   = val_width(K)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [DIGIT_W-1:0] in_digit,
    input  logic               in_last,
    output logic               in_ready,
    output logic               bank_valid,
    output logic [VAL_W-1:0]   bank_value,
    output logic [ACC_W-1:0]   total,
    output logic [15:0]        bank_count,
    output logic               err
);

    localparam int unsigned CNT_W = $clog2(K + 1);

    state_e                    state_q, state_d;
    logic [7:0]                pos_q, pos_d;
    logic [CNT_W-1:0]          conv_q, conv_d;
    logic [VAL_W-1:0]          acc_q, acc_d;
    logic [VAL_W-1:0]          bank_value_q, bank_value_d;
    logic                      bank_valid_q, bank_valid_d;
    logic [ACC_W-1:0]          total_q, total_d;
    logic [15:0]               count_q, count_d;
    logic                      err_q, err_d;
    logic                      push, flush, at_end;
    logic [K-1:0][DIGIT_W-1:0] stack;
    logic [DIGIT_W-1:0]        cur_digit;

    joltage_stack #(
        .K        (K),
        .LINE_LEN (LINE_LEN)
    ) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (push),
        .digit_i (in_digit),
        .pos_i   (pos_q),
        .stack_o (stack)
    );

    always_comb begin
        cur_digit = '0;
        for (int j = 0; j < int'(K); j++) begin
            if (conv_q == CNT_W'(j)) cur_digit = stack[j];
        end
    end

    assign at_end = (pos_q == 8'(LINE_LEN - 1));

    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        conv_d       = conv_q;
        acc_d        = acc_q;
        bank_valid_d = 1'b0;
        bank_value_d = bank_value_q;
        total_d      = total_q;
        count_d      = count_q;
        err_d        = err_q;
        push         = 1'b0;
        flush        = 1'b0;
        unique case (state_q)
            StAccept: begin
                if (in_valid) begin
                    if (in_last && at_end) begin
                        push    = 1'b1;
                        pos_d   = '0;
                        conv_d  = '0;
                        acc_d   = '0;
                        state_d = StConvert;
                    end else if (in_last || at_end) begin
                        // Misframed bank: drop everything gathered so far.
                        err_d = 1'b1;
                        flush = 1'b1;
                        pos_d = '0;
                    end else begin
                        push  = 1'b1;
                        pos_d = pos_q + 8'd1;
                    end
                end
            end
            StConvert: begin
                acc_d  = acc_q * VAL_W'(10) + VAL_W'(cur_digit);
                conv_d = conv_q + CNT_W'(1);
                if (conv_q == CNT_W'(K - 1)) state_d = StEmit;
            end
            StEmit: begin
                bank_valid_d = 1'b1;
                bank_value_d = acc_q;
                total_d      = total_q + ACC_W'(acc_q);
                count_d      = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                flush        = 1'b1;
                state_d      = StAccept;
            end
            default: state_d = StAccept;
        endcase
        if (clear) begin
            state_d      = StAccept;
            pos_d        = '0;
            conv_d       = '0;
            acc_d        = '0;
            bank_valid_d = 1'b0;
            bank_value_d = '0;
            total_d      = '0;
            count_d      = '0;
            err_d        = 1'b0;
            push         = 1'b0;
            flush        = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StAccept;
            pos_q        <= '0;
            conv_q       <= '0;
            acc_q        <= '0;
            bank_valid_q <= 1'b0;
            bank_value_q <= '0;
            total_q      <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            conv_q       <= conv_d;
            acc_q        <= acc_d;
            bank_valid_q <= bank_valid_d;
            bank_value_q <= bank_value_d;
            total_q      <= total_d;
            count_q      <= count_d;
            err_q        <= err_d;
        end
    end

    assign in_ready   = (state_q == StAccept);
    assign bank_valid = bank_valid_q;
    assign bank_value = bank_value_q;
    assign total      = total_q;
    assign bank_count = count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_joltage_selector.sv
// Drives a K=2 and a K=12 selector in lockstep and checks them against a greedy model.
module tb_joltage_selector;

    localparam int KA = 2;
    localparam int KB = 12;
    localparam int LL = 15;
    localparam int VA = 7;
    localparam int VB = 40;

    typedef logic [3:0] bank_t [LL];

    logic clk = 1'b0;
    logic rst_n, clear, in_valid, in_last;
    logic [3:0] in_digit;

    logic          rdy_a, bv_a, err_a, rdy_b, bv_b, err_b;
    logic [VA-1:0] val_a;
    logic [VB-1:0] val_b;
    logic [63:0]   tot_a, tot_b;
    logic [15:0]   cnt_a, cnt_b;

    joltage_selector #(.K(KA), .LINE_LEN(LL), .ACC_W(64)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_digit(in_digit),
        .in_last(in_last), .in_ready(rdy_a), .bank_valid(bv_a), .bank_value(val_a),
        .total(tot_a), .bank_count(cnt_a), .err(err_a)
    );

    joltage_selector #(.K(KB), .LINE_LEN(LL), .ACC_W(64)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_digit(in_digit),
        .in_last(in_last), .in_ready(rdy_b), .bank_valid(bv_b), .bank_value(val_b),
        .total(tot_b), .bank_count(cnt_b), .err(err_b)
    );

    always #5 clk = ~clk;

    logic        o_rdy [2];
    logic        o_bv  [2];
    logic        o_err [2];
    logic [63:0] o_val [2];
    logic [63:0] o_tot [2];
    logic [15:0] o_cnt [2];
    assign o_rdy[0] = rdy_a;      assign o_rdy[1] = rdy_b;
    assign o_bv[0]  = bv_a;       assign o_bv[1]  = bv_b;
    assign o_err[0] = err_a;      assign o_err[1] = err_b;
    assign o_val[0] = 64'(val_a); assign o_val[1] = 64'(val_b);
    assign o_tot[0] = tot_a;      assign o_tot[1] = tot_b;
    assign o_cnt[0] = cnt_a;      assign o_cnt[1] = cnt_b;

    int nvec = 0;
    int nerr = 0;
    bit gap_en;

    logic [63:0] m_last [2];
    logic [63:0] m_tot  [2];
    int          m_cnt  [2];
    bit          m_err  [2];

    string banks [4] = '{"987654321111111", "811111111111119",
                         "234234234234278", "818181911112111"};

    function automatic int kk(input int d);
        return (d == 0) ? KA : KB;
    endfunction

    function automatic string sfx(input int d);
        return (d == 0) ? "_a" : "_b";
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic bank_t to_bank(input string s);
        bank_t b;
        for (int i = 0; i < LL; i++) b[i] = 4'(s[i] - 8'h30);
        return b;
    endfunction

    // Greedy reference: each output digit is the leftmost maximum of the window that
    // still leaves enough digits for the remaining positions.
    function automatic logic [63:0] best(input bank_t b, input int k);
        logic [63:0] v;
        int start, hi, bi;
        v = 0;
        start = 0;
        for (int p = 0; p < k; p++) begin
            hi = LL - (k - p);
            bi = start;
            for (int j = start; j <= hi; j++) if (b[j] > b[bi]) bi = j;
            v = v * 10 + 64'(b[bi]);
            start = bi + 1;
        end
        return v;
    endfunction

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            m_last[d] = 0; m_tot[d] = 0; m_cnt[d] = 0; m_err[d] = 0;
        end
    endtask

    task automatic check_idle(input string tag);
        for (int d = 0; d < 2; d++) begin
            check_eq({tag, "_rdy", sfx(d)}, 64'(o_rdy[d]), 64'd1);
            check_eq({tag, "_bv", sfx(d)},  64'(o_bv[d]),  64'd0);
            check_eq({tag, "_val", sfx(d)}, o_val[d],      64'd0);
            check_eq({tag, "_tot", sfx(d)}, o_tot[d],      64'd0);
            check_eq({tag, "_cnt", sfx(d)}, 64'(o_cnt[d]), 64'd0);
            check_eq({tag, "_err", sfx(d)}, 64'(o_err[d]), 64'd0);
        end
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_digit = 4'($urandom_range(15, 0));
        in_last  = 1'($urandom_range(1, 0));
        @(posedge clk);
        #2;
    endtask

    task automatic send_digit(input logic [3:0] dg, input logic lst);
        int n;
        n = 0;
        while (gap_en && n < 6 && $urandom_range(1, 0) == 1) begin
            idle_cycle();
            n++;
        end
        n = 0;
        while (!(rdy_a && rdy_b) && n < 64) begin
            idle_cycle();
            n++;
        end
        if (n >= 64) check_eq("ready_wait", 64'(rdy_a && rdy_b), 64'd1);
        in_valid = 1'b1;
        in_digit = dg;
        in_last  = lst;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_digit = 4'($urandom_range(15, 0));
    endtask

    task automatic send_bank(input bank_t b, input int last_at);
        for (int i = 0; i < LL; i++) begin
            send_digit(b[i], i == last_at);
            if (i == last_at) break;
        end
    endtask

    // Cycle c is sampled at the falling edge following transfer edge + c.
    task automatic watch_bank(input logic [63:0] exp_a, input logic [63:0] exp_b, input bit ok,
                              input int clear_c);
        logic [63:0] expv [2];
        bit          pulse [2];
        logic [63:0] ev;
        expv[0] = exp_a;
        expv[1] = exp_b;
        for (int d = 0; d < 2; d++) pulse[d] = ok && !(clear_c >= 0 && clear_c <= kk(d));
        for (int c = 0; c <= KB + 1; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check_eq({"in_ready", sfx(d)}, 64'(o_rdy[d]),
                         64'(!ok || c > kk(d) || (clear_c >= 0 && c > clear_c)));
                check_eq({"bank_valid", sfx(d)}, 64'(o_bv[d]), 64'(pulse[d] && c == kk(d) + 1));
                if (clear_c < 0 || c <= clear_c) begin
                    ev = (pulse[d] && c >= kk(d) + 1) ? expv[d] : m_last[d];
                    check_eq({"bank_value", sfx(d)}, o_val[d], ev);
                end
            end
            clear = (c == clear_c);
        end
        for (int d = 0; d < 2; d++) begin
            if (pulse[d]) begin
                m_last[d] = expv[d];
                m_tot[d]  = m_tot[d] + expv[d];
                m_cnt[d]  = m_cnt[d] + 1;
            end
            if (!ok) m_err[d] = 1'b1;
        end
        if (clear_c >= 0) reset_model();
        for (int d = 0; d < 2; d++) begin
            check_eq({"total", sfx(d)},      o_tot[d],      m_tot[d]);
            check_eq({"bank_count", sfx(d)}, 64'(o_cnt[d]), 64'(m_cnt[d]));
            check_eq({"err", sfx(d)},        64'(o_err[d]), 64'(m_err[d]));
            check_eq({"hold_value", sfx(d)}, o_val[d],      m_last[d]);
        end
    endtask

    task automatic run_bank(input bank_t b);
        send_bank(b, LL - 1);
        watch_bank(best(b, KA), best(b, KB), 1'b1, -1);
    endtask

    initial begin
        bank_t b;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_digit = '0; in_last = 1'b0;
        gap_en = 1'b0;
        reset_model();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset");

        // Reference banks, back to back.
        for (int i = 0; i < 4; i++) run_bank(to_bank(banks[i]));
        check_eq("k2_total_357", tot_a, 64'd357);
        check_eq("k2_count_4", 64'(cnt_a), 64'd4);
        check_eq("k12_total", tot_b, 64'd3121910778619);

        // Same banks with in_valid gaps.
        gap_en = 1'b1;
        for (int i = 0; i < 4; i++) run_bank(to_bank(banks[i]));
        gap_en = 1'b0;

        // Early in_last, then a good bank.
        send_bank(to_bank(banks[0]), 10);
        watch_bank(64'd0, 64'd0, 1'b0, -1);
        run_bank(to_bank(banks[0]));
        check_eq("after_err_val_98", 64'(val_a), 64'd98);

        // Missing in_last, then a good bank.
        send_bank(to_bank(banks[1]), -1);
        watch_bank(64'd0, 64'd0, 1'b0, -1);
        run_bank(to_bank(banks[2]));

        // Reset in the middle of bank 2.
        run_bank(to_bank(banks[0]));
        b = to_bank(banks[1]);
        for (int i = 0; i < 7; i++) send_digit(b[i], 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        reset_model();
        @(negedge clk);
        check_idle("midreset");
        run_bank(to_bank(banks[2]));
        run_bank(to_bank(banks[3]));
        check_eq("reset_total_170", tot_a, 64'd170);
        check_eq("reset_count_2", 64'(cnt_a), 64'd2);

        // Clear on the K=2 EMIT cycle (also aborts the K=12 conversion), after an error.
        send_bank(to_bank(banks[3]), 4);
        watch_bank(64'd0, 64'd0, 1'b0, -1);
        b = to_bank(banks[0]);
        send_bank(b, LL - 1);
        watch_bank(best(b, KA), best(b, KB), 1'b1, KA);
        check_eq("clear_total_0", tot_a, 64'd0);
        check_eq("clear_count_0", 64'(cnt_a), 64'd0);
        check_eq("clear_err_0", 64'(err_a), 64'd0);

        // Clear on the K=12 EMIT cycle.
        run_bank(to_bank(banks[1]));
        b = to_bank(banks[2]);
        send_bank(b, LL - 1);
        watch_bank(best(b, KA), best(b, KB), 1'b1, KB);

        // Clear on the same edge as a transfer: the digit must be discarded.
        b = to_bank(banks[3]);
        for (int i = 0; i < 5; i++) send_digit(b[i], 1'b0);
        clear = 1'b1; in_valid = 1'b1; in_digit = 4'd9; in_last = 1'b0;
        @(posedge clk);
        #2;
        clear = 1'b0; in_valid = 1'b0;
        reset_model();
        @(negedge clk);
        check_idle("clear_xfer");
        run_bank(b);
        check_eq("clear_xfer_val_92", 64'(val_a), 64'd92);

        // Random banks, zeros included.
        for (int n = 0; n < 20; n++) begin
            gap_en = 1'($urandom_range(1, 0));
            for (int i = 0; i < LL; i++) b[i] = 4'($urandom_range(9, 0));
            run_bank(b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/joltage_selector.md
JOLTAGE_SELECTOR -- requirements
Module: joltage_selector

Interface
REQ-001 Parameter K, default 12: digits selected per bank (legal range 1..16).
REQ-002 Parameter LINE_LEN, default 100: digits per bank (legal range K..255).
REQ-003 Parameter ACC_W, default 64: width of the running total.
REQ-004 Derived constant VAL_W = ceil(log2(10^K)) (40 for K=12, 7 for K=2): width of the bank value.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 clear  in  1  synchronous clear of total, bank_count and err; same effect as reset.
REQ-008 in_valid  in  1  digit offered.
REQ-009 in_digit  in  4  digit value 1..9.
REQ-010 in_last  in  1  marks the final digit of a bank.
REQ-011 in_ready  out  1  block accepts a digit on this edge.
REQ-012 bank_valid  out  1  one-cycle pulse: bank_value is valid.
REQ-013 bank_value  out  VAL_W  largest K-digit number selectable in order from the bank.
REQ-014 total  out  ACC_W  sum of all accepted bank values, wrapping modulo 2^ACC_W.
REQ-015 bank_count  out  16  number of banks summed, saturating at 65535.
REQ-016 err  out  1  sticky flag: a framing error has occurred.

Function
REQ-017 The block SHALL run an FSM with states ACCEPT, CONVERT and EMIT; in_ready = 1 only in ACCEPT.
REQ-018 A digit transfers on an edge where in_valid and in_ready are both 1; gaps in in_valid SHALL NOT change state.
REQ-019 Per transfer at position i (0-based): rem = LINE_LEN - i; lb = max(0, K - rem).
REQ-020 Let p be the smallest index >= lb such that every stack[q], q in [p, size), is less than in_digit. If p < size: stack[p] = in_digit and size = p+1. Otherwise, if size < K: push. Otherwise: drop the digit. All of this completes in a single cycle.
REQ-021 When in_last is transferred at i = LINE_LEN-1, the FSM SHALL enter CONVERT.
REQ-022 CONVERT SHALL last exactly K cycles, computing acc = acc*10 + stack[j] for j = 0..K-1, MSB digit first.
REQ-023 EMIT SHALL last 1 cycle. In it: bank_valid = 1; bank_value = acc; total += acc; bank_count increments. The FSM then returns to ACCEPT with size = 0 and i = 0.
REQ-024 Latency: bank_valid asserts K+1 cycles after the in_last transfer edge. Throughput: LINE_LEN + K + 1 cycles per bank.
REQ-025 bank_value SHALL hold its value until the next EMIT.
REQ-026 Framing error, case 1: in_last at i != LINE_LEN-1. The block SHALL set err, discard the bank (no EMIT, total unchanged) and reset size and i.
REQ-027 Framing error, case 2: no in_last at i = LINE_LEN-1. Same action as REQ-026, and the next digit starts a new bank.
REQ-028 in_digit = 0 SHALL be processed arithmetically like any other digit, with no error.
REQ-029 If clear and a transfer occur on the same edge, clear SHALL win and the digit SHALL be discarded.
REQ-030 A clear asserted during CONVERT or EMIT SHALL abort the bank: no bank_valid pulse.

Reset
REQ-031 While rst_n = 0 at an edge, the block SHALL set: state = ACCEPT, in_ready = 1 from the next cycle, bank_valid = 0, bank_value = 0, total = 0, bank_count = 0, err = 0, size = 0, i = 0, acc = 0.
REQ-032 A reset mid-bank or mid-CONVERT SHALL discard all partial state; no pulse is produced.
REQ-033 Stack contents need no reset; entries at or above size are don't-care.

Structure
REQ-034 Shared package aoc_day3_pkg SHALL hold: the FSM state encoding, DIGIT_W = 4, and the VAL_W derivation function (ceil log2 of 10^K).
REQ-035 The stack and the REQ-020 update logic SHALL be one sub-module, joltage_stack (params K, LINE_LEN). The FSM, conversion and accumulation live in joltage_selector.

Verification
REQ-036 K=2, LINE_LEN=15; banks 987654321111111, 811111111111119, 234234234234278, 818181911112111 -> bank_values 98, 89, 78, 92; total 357; bank_count 4.
REQ-037 K=12, same four banks -> 987654321111, 811111111119, 434234234278, 888911112111; total 3121910778619.
REQ-038 K=12, in_valid randomly low 50% of cycles -> same results as REQ-037. Check bank_valid occurs exactly K+1 cycles after each in_last transfer, and in_ready = 0 during CONVERT and EMIT.
REQ-039 K=2, LINE_LEN=15, in_last at digit 10 -> err = 1, no pulse, total unchanged. Next valid bank 987654321111111 -> 98.
REQ-040 rst_n low for 1 cycle in the middle of bank 2 of REQ-036 -> all outputs 0. Banks 3 and 4 resent -> total 170, bank_count 2.
REQ-041 clear asserted on the EMIT cycle of bank 1 -> no pulse, total 0, bank_count 0, err 0.
